hangman_ctrl: RTL
=================

HANGMAN_CTRL -- requirements
Module: hangman_ctrl

Interface
REQ-001 SHALL have parameter MAX_WRONG, default 6, meaning wrong guesses allowed before loss (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle player start/continue strobe.
REQ-005 SHALL have port guess_valid  input  1  guess offered this cycle.
REQ-006 SHALL have port guess_letter  input  5  letter code, a=1 .. z=26; 0 and 27..31 illegal.
REQ-007 SHALL have port word  input  30  six 5-bit codes, position 0 = word[29:25], position 5 = word[4:0]; code 0 = blank position.
REQ-008 SHALL have port mask  input  26  mask[c-1]=1 iff letter code c occurs in word.
REQ-009 SHALL have port guess_ready  output  1  high only in WAIT.
REQ-010 SHALL have port revealed  output  6  revealed[5-p]=1 when position p is shown.
REQ-011 SHALL have port guessed  output  26  guessed[c-1]=1 once letter c is accepted.
REQ-012 SHALL have port wrong_count  output  4  accepted misses this level.
REQ-013 SHALL have port guess_err  output  1  one-cycle pulse: illegal code.
REQ-014 SHALL have port guess_dup  output  1  one-cycle pulse: letter already guessed.
REQ-015 SHALL have port level_done  output  1  one-cycle pulse driving the level selector's start_game.
REQ-016 SHALL have port lost_game  output  1  high in LOSE state.
REQ-017 SHALL have port win  output  1  high in WIN state.
REQ-018 SHALL have port state  output  3  encoded FSM state for display.

Function
REQ-019 SHALL implement states IDLE=0, LOAD=1, WAIT=2, CHECK=3, WIN=4, LOSE=5; codes 6,7 SHALL return to IDLE next cycle.
REQ-020 IDLE: start -> LOAD; other inputs ignored.
REQ-021 LOAD: one cycle; clear guessed and wrong_count; -> WAIT (lets word/mask settle).
REQ-022 WAIT: guess_valid sampled with guess_ready=1 registers guess_letter -> CHECK; guess_valid otherwise ignored (no queue).
REQ-023 CHECK, illegal code: guess_err pulse, no state update, -> WAIT.
REQ-024 CHECK, guessed[c-1]=1: guess_dup pulse, no penalty, -> WAIT.
REQ-025 CHECK, new letter: set guessed[c-1]; if mask[c-1]=0 increment wrong_count.
REQ-026 CHECK next state: ((mask & ~guessed_next)==0) -> WIN; else wrong_count_next==MAX_WRONG -> LOSE; else WAIT; win has priority.
REQ-027 revealed SHALL be combinational from word and guessed: bit set if code 0 or guessed[code-1]; codes 27..31 never revealed.
REQ-028 WIN: start -> level_done pulse same edge as transition, -> LOAD (next level).
REQ-029 LOSE: lost_game=1; start -> level_done pulse, -> IDLE; lost_game drops on leaving LOSE.
REQ-030 Guess-to-result latency SHALL be 2 cycles (accept edge, CHECK edge); at most one guess per 2 cycles.
REQ-031 wrong_count SHALL saturate at 15 and never wrap.
REQ-032 start in WAIT or CHECK SHALL be ignored.

Reset
REQ-033 reset low SHALL immediately force IDLE, guessed=0, wrong_count=0, all pulses and flags 0, guess_ready=0, regardless of state.
REQ-034 Reset release SHALL take effect on the next clk edge only; no guess accepted until LOAD completes.

Verification
REQ-035 word=e,n,c,e,l,s (5,14,3,5,12,19), start, guess 5 -> after 2 cycles guessed[4]=1, revealed=6'b100100, wrong_count=0.
REQ-036 Same word, guess 1 twice -> first: wrong_count=1; second: guess_dup pulse, wrong_count stays 1.
REQ-037 Guess codes 0 and 31 -> guess_err pulse each, guessed unchanged, back in WAIT.
REQ-038 MAX_WRONG=6, six distinct misses -> state=LOSE, lost_game=1; start -> level_done pulse, IDLE.
REQ-039 Guess 5,14,3,12,19 -> WIN after last CHECK; start -> level_done pulse, LOAD, guessed cleared.
REQ-040 Assert reset low in CHECK mid-guess -> outputs cleared asynchronously, state=IDLE, no pulse emitted.

Source files
------------

// File: rtl/hangman_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hangman_ctrl
// Description : Hangman game controller. Accepts one letter guess at a time,
//               tracks guessed letters and misses, reveals word positions and
//               sequences WIN / LOSE / next-level handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module hangman_ctrl #(
    parameter int MAX_WRONG = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        guess_valid,
    input  logic [4:0]  guess_letter,
    input  logic [29:0] word,
    input  logic [25:0] mask,
    output logic        guess_ready,
    output logic [5:0]  revealed,
    output logic [25:0] guessed,
    output logic [3:0]  wrong_count,
    output logic        guess_err,
    output logic        guess_dup,
    output logic        level_done,
    output logic        lost_game,
    output logic        win,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    localparam logic [3:0] c_max_wrong = 4'(MAX_WRONG);
    localparam logic [3:0] c_wrong_sat = 4'd15;

    state_t      r_state, w_state_next;
    logic [25:0] r_guessed, w_guessed_next;
    logic [3:0]  r_wrong, w_wrong_next;
    logic [4:0]  r_letter, w_letter_next;
    logic        r_err, w_err_next;
    logic        r_dup, w_dup_next;
    logic        r_level_done, w_level_done_next;

    // One-hot of the registered letter; codes 0 and 27..31 shift out to zero.
    logic [25:0] w_letter_oh;
    logic        w_illegal;
    logic        w_already;
    logic        w_hit;
    logic [25:0] w_guessed_new;
    logic [3:0]  w_wrong_new;

    assign w_letter_oh   = 26'd1 << (r_letter - 5'd1);
    assign w_illegal     = (r_letter == 5'd0) || (r_letter > 5'd26);
    assign w_already     = |(r_guessed & w_letter_oh);
    assign w_hit         = |(mask & w_letter_oh);
    assign w_guessed_new = r_guessed | w_letter_oh;
    assign w_wrong_new   = (!w_hit && (r_wrong != c_wrong_sat)) ? r_wrong + 4'd1 : r_wrong;

    // Next-state and datapath update for every game state.
    always_comb begin
        w_state_next      = r_state;
        w_guessed_next    = r_guessed;
        w_wrong_next      = r_wrong;
        w_letter_next     = r_letter;
        w_err_next        = 1'b0;
        w_dup_next        = 1'b0;
        w_level_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_guessed_next = 26'd0;
                w_wrong_next   = 4'd0;
                w_state_next   = S_WAIT;
            end
            S_WAIT: begin
                if (guess_valid) begin
                    w_letter_next = guess_letter;
                    w_state_next  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_illegal) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_WAIT;
                end else if (w_already) begin
                    w_dup_next   = 1'b1;
                    w_state_next = S_WAIT;
                end else begin
                    w_guessed_next = w_guessed_new;
                    w_wrong_next   = w_wrong_new;
                    // Completing the word wins even on what would be the last miss.
                    if ((mask & ~w_guessed_new) == 26'd0)
                        w_state_next = S_WIN;
                    else if (w_wrong_new == c_max_wrong)
                        w_state_next = S_LOSE;
                    else
                        w_state_next = S_WAIT;
                end
            end
            S_WIN: begin
                if (start) begin
                    w_level_done_next = 1'b1;
                    w_state_next      = S_LOAD;
                end
            end
            S_LOSE: begin
                if (start) begin
                    w_level_done_next = 1'b1;
                    w_state_next      = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_guessed    <= 26'd0;
            r_wrong      <= 4'd0;
            r_letter     <= 5'd0;
            r_err        <= 1'b0;
            r_dup        <= 1'b0;
            r_level_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_guessed    <= w_guessed_next;
            r_wrong      <= w_wrong_next;
            r_letter     <= w_letter_next;
            r_err        <= w_err_next;
            r_dup        <= w_dup_next;
            r_level_done <= w_level_done_next;
        end
    end

    // Position p is shown when blank or its letter was guessed; out-of-range codes never match.
    for (genvar p = 0; p < 6; p++) begin : g_reveal
        logic [4:0]  w_code;
        logic [25:0] w_code_oh;
        assign w_code        = word[29-5*p -: 5];
        assign w_code_oh     = 26'd1 << (w_code - 5'd1);
        assign revealed[5-p] = (w_code == 5'd0) || (|(r_guessed & w_code_oh));
    end

    assign guess_ready = (r_state == S_WAIT);
    assign lost_game   = (r_state == S_LOSE);
    assign win         = (r_state == S_WIN);
    assign state       = r_state;
    assign guessed     = r_guessed;
    assign wrong_count = r_wrong;
    assign guess_err   = r_err;
    assign guess_dup   = r_dup;
    assign level_done  = r_level_done;

endmodule
`default_nettype wire
